// File: rtl/dispense_sequencer.sv
// Beverage dispense sequencer: steps syrup, water and CO2 valves in order,
// each phase timed by an external countdown timer through a four-phase
// start/end handshake. Cancel or cup removal aborts the dispense.
module dispense_sequencer #(
  parameter logic [31:0] P_T_SYRUP = 32'd50,
  parameter logic [31:0] P_T_WATER = 32'd200,
  parameter logic [31:0] P_T_GAS   = 32'd100
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_request,
  input  logic        i_cup_present,
  input  logic        i_cancel,
  input  logic        i_timer_end,
  output logic        o_timer_start,
  output logic [31:0] o_timer_value,
  output logic        o_valve_syrup,
  output logic        o_valve_water,
  output logic        o_valve_gas,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_abort
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_RELEASE = 2'd2,
    S_ABORT   = 2'd3
  } state_t;

  localparam logic [1:0] PH_SYRUP = 2'd0;
  localparam logic [1:0] PH_WATER = 2'd1;
  localparam logic [1:0] PH_GAS   = 2'd2;

  state_t     state;
  logic [1:0] phase;
  logic [2:0] valves;   // {gas, water, syrup}, at most one bit set
  logic       abort_req;
  logic       start_ok;

  assign abort_req = i_cancel | ~i_cup_present;
  // A new dispense also waits for the timer to have dropped end, so the
  // handshake is never restarted while the timer still reports completion.
  assign start_ok  = i_request & i_cup_present & ~i_cancel & ~i_timer_end;

  assign o_valve_syrup = valves[0];
  assign o_valve_water = valves[1];
  assign o_valve_gas   = valves[2];

  function automatic logic [31:0] phase_time(input logic [1:0] ph);
    case (ph)
      PH_SYRUP: phase_time = P_T_SYRUP;
      PH_WATER: phase_time = P_T_WATER;
      default:  phase_time = P_T_GAS;
    endcase
  endfunction

  function automatic logic [2:0] phase_valve(input logic [1:0] ph);
    case (ph)
      PH_SYRUP: phase_valve = 3'b001;
      PH_WATER: phase_valve = 3'b010;
      default:  phase_valve = 3'b100;
    endcase
  endfunction

  // State transitions with outputs registered from the state being entered.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      phase         <= PH_SYRUP;
      valves        <= 3'b000;
      o_timer_start <= 1'b0;
      o_timer_value <= 32'd0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_abort       <= 1'b0;
    end else begin
      // Defaults describe RELEASE/ABORT/IDLE: everything off, busy unchanged.
      o_done        <= 1'b0;
      o_abort       <= 1'b0;
      o_timer_start <= 1'b0;
      o_timer_value <= 32'd0;
      valves        <= 3'b000;
      o_busy        <= (state != S_IDLE);
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state         <= S_RUN;
            phase         <= PH_SYRUP;
            o_timer_start <= 1'b1;
            o_timer_value <= P_T_SYRUP;
            valves        <= phase_valve(PH_SYRUP);
            o_busy        <= 1'b1;
          end
        end
        S_RUN: begin
          if (abort_req) begin
            state   <= S_ABORT;
            o_abort <= 1'b1;
          end else if (i_timer_end) begin
            state <= S_RELEASE;
          end else begin
            o_timer_start <= 1'b1;
            o_timer_value <= phase_time(phase);
            valves        <= phase_valve(phase);
          end
        end
        S_RELEASE: begin
          if (abort_req) begin
            state   <= S_ABORT;
            o_abort <= 1'b1;
          end else if (!i_timer_end) begin
            if (phase == PH_GAS) begin
              state  <= S_IDLE;
              phase  <= PH_SYRUP;
              o_done <= 1'b1;
              o_busy <= 1'b0;
            end else begin
              state         <= S_RUN;
              phase         <= phase + 2'd1;
              o_timer_start <= 1'b1;
              o_timer_value <= phase_time(phase + 2'd1);
              valves        <= phase_valve(phase + 2'd1);
            end
          end
        end
        default: begin
          if (!i_timer_end) begin
            state  <= S_IDLE;
            phase  <= PH_SYRUP;
            o_busy <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed bench for dispense_sequencer: the timer end input is driven by
// hand so every output vector can be written down cycle by cycle.
module tb_dispense_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req;
  logic        cup;
  logic        cancel;
  logic        tend;
  logic        t_start;
  logic [31:0] t_value;
  logic        v_syrup;
  logic        v_water;
  logic        v_gas;
  logic        busy;
  logic        done;
  logic        abort;

  int total = 0;
  int bad   = 0;

  dispense_sequencer #(
    .P_T_SYRUP(32'd3),
    .P_T_WATER(32'd5),
    .P_T_GAS  (32'd4)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_request    (req),
    .i_cup_present(cup),
    .i_cancel     (cancel),
    .i_timer_end  (tend),
    .o_timer_start(t_start),
    .o_timer_value(t_value),
    .o_valve_syrup(v_syrup),
    .o_valve_water(v_water),
    .o_valve_gas  (v_gas),
    .o_busy       (busy),
    .o_done       (done),
    .o_abort      (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare the full output vector {start,syrup,water,gas,busy,done,abort,value}.
  task automatic chk(input string tag, input logic st, input logic sy,
                     input logic wa, input logic ga, input logic bu,
                     input logic dn, input logic ab, input logic [31:0] val);
    logic [38:0] obs;
    logic [38:0] exp;
    obs = {t_start, v_syrup, v_water, v_gas, busy, done, abort, t_value};
    exp = {st, sy, wa, ga, bu, dn, ab, val};
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Shorthands for the recurring output patterns.
  task automatic chk_idle(input string tag);
    chk(tag, 0, 0, 0, 0, 0, 0, 0, 32'd0);
  endtask
  task automatic chk_rel(input string tag);
    chk(tag, 0, 0, 0, 0, 1, 0, 0, 32'd0);
  endtask
  task automatic chk_syrup(input string tag);
    chk(tag, 1, 1, 0, 0, 1, 0, 0, 32'd3);
  endtask
  task automatic chk_water(input string tag);
    chk(tag, 1, 0, 1, 0, 1, 0, 0, 32'd5);
  endtask
  task automatic chk_gas(input string tag);
    chk(tag, 1, 0, 0, 1, 1, 0, 0, 32'd4);
  endtask

  initial begin
    rst_n  = 1'b0;
    req    = 1'b0;
    cup    = 1'b0;
    cancel = 1'b0;
    tend   = 1'b0;

    // Reset state
    #3;
    chk_idle("reset_state");
    step();
    chk_idle("reset_hold");
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk_idle("idle_after_reset");

    // Normal dispense: syrup, water, gas, done
    cup = 1'b1;
    req = 1'b1;
    step();
    chk_syrup("syrup_run");
    req = 1'b0;
    step();
    chk_syrup("syrup_hold");
    tend = 1'b1;
    step();
    chk_rel("syrup_release");
    step();
    chk_rel("syrup_hs_wait");
    tend = 1'b0;
    step();
    chk_water("water_run");
    tend = 1'b1;
    step();
    chk_rel("water_release");
    tend = 1'b0;
    step();
    chk_gas("gas_run");
    tend = 1'b1;
    step();
    chk_rel("gas_release");
    tend = 1'b0;
    req  = 1'b1;
    step();
    chk("done_pulse", 0, 0, 0, 0, 0, 1, 0, 32'd0);
    step();
    chk_syrup("restart_after_idle");
    req = 1'b0;

    // Cancel during water
    tend = 1'b1;
    step();
    chk_rel("c_syrup_release");
    tend = 1'b0;
    step();
    chk_water("c_water_run");
    cancel = 1'b1;
    step();
    chk("cancel_abort", 0, 0, 0, 0, 1, 0, 1, 32'd0);
    cancel = 1'b0;
    tend   = 1'b1;
    step();
    chk_rel("abort_hold");
    tend = 1'b0;
    step();
    chk_idle("abort_exit");

    // No cup: request ignored
    cup = 1'b0;
    req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle("no_cup");
    end

    // Timer end high in IDLE is ignored until it clears
    cup  = 1'b1;
    tend = 1'b1;
    step();
    chk_idle("idle_end_ignored");
    tend = 1'b0;
    step();
    chk_syrup("start_after_end_clear");
    req = 1'b0;

    // Cup removed together with timer end in gas phase
    tend = 1'b1;
    step();
    tend = 1'b0;
    step();
    chk_water("g_water_run");
    tend = 1'b1;
    step();
    tend = 1'b0;
    step();
    chk_gas("g_gas_run");
    cup  = 1'b0;
    tend = 1'b1;
    step();
    chk("cup_gone_gas", 0, 0, 0, 0, 1, 0, 1, 32'd0);
    cup  = 1'b1;
    tend = 1'b0;
    step();
    chk_idle("cup_abort_to_idle");

    // Slow timer: end held 6 cycles after start falls
    req = 1'b1;
    step();
    chk_syrup("s_syrup_run");
    req  = 1'b0;
    tend = 1'b1;
    step();
    chk_rel("s_release");
    for (int i = 0; i < 6; i++) begin
      step();
      chk_rel("slow_hs_hold");
    end
    tend = 1'b0;
    step();
    chk_water("s_water_run");
    tend = 1'b1;
    step();
    tend = 1'b0;
    step();
    chk_gas("s_gas_run");
    tend = 1'b1;
    step();
    tend = 1'b0;
    step();
    chk("done_pulse2", 0, 0, 0, 0, 0, 1, 0, 32'd0);

    // Async reset in syrup phase, between edges
    req = 1'b1;
    step();
    chk_syrup("r_syrup_run");
    req = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle("async_reset");
    step();
    chk_idle("reset_no_abort");
    @(negedge clk);
    rst_n = 1'b1;
    req   = 1'b1;
    step();
    chk_syrup("fresh_syrup");
    req = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
